score_sequencer: RTL and testbench

Game-side driver for the high-score table. Converts food-eaten events (with a point value) from the snake game FSM into a paced train of single-cycle `increment` strobes. On game over, drains any outstanding points, raises `en`, and steps `decider` through the table entries for display. Sits between the game control FSM and the high-score table / hex display path.

---
 rtl/score_sequencer_if.sv | 23 ++
 rtl/score_sequencer.sv | 119 +++++++++++
 tb/tb_score_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_sequencer_if.sv
// Event/strobe bundle between the snake game FSM (master) and score_sequencer (slave).
interface score_sequencer_if;
   logic       start;
   logic       eat;
   logic [2:0] points;
   logic       game_over;
   logic       view;
   logic       increment;
   logic       en;
   logic [1:0] decider;
   logic       busy;
   logic [9:0] score;

   modport master (
      output start, eat, points, game_over, view,
      input  increment, en, decider, busy, score
   );

   modport slave (
      input  start, eat, points, game_over, view,
      output increment, en, decider, busy, score
   );
endinterface

// File: rtl/score_sequencer.sv
// Turns food-eaten events into paced increment strobes, then drains and browses
// the high-score table entries after game over.
module score_sequencer #(
   parameter int MAX_SCORE   = 999,
   parameter int CYCLE_TICKS = 50_000_000
) (
   input  logic             clk,
   input  logic             rst,
   score_sequencer_if.slave bus
);
   localparam int            TW         = $clog2(CYCLE_TICKS);
   localparam logic [TW-1:0] TIMER_LAST = TW'(CYCLE_TICKS - 1);
   localparam logic [9:0]    SCORE_MAX  = 10'(MAX_SCORE);

   typedef enum logic [1:0] {IDLE, PLAY, DRAIN, BROWSE} state_e;

   state_e        state_q, state_d;
   logic [5:0]    pending_q, pending_d;
   logic [9:0]    score_q, score_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    decider_q, decider_d;
   logic          increment_q, increment_d;
   logic          en_q, en_d;
   logic          busy_q, busy_d;
   logic          strobe;
   logic [6:0]    pending_sum;

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      pending_d   = pending_q;
      score_d     = score_q;
      timer_d     = timer_q;
      decider_d   = decider_q;
      en_d        = en_q;
      increment_d = 1'b0;
      strobe      = 1'b0;
      pending_sum = '0;

      if (bus.start) begin
         state_d   = PLAY;
         pending_d = '0;
         score_d   = '0;
         timer_d   = '0;
         decider_d = 2'd0;
         en_d      = 1'b0;
      end else begin
         case (state_q)
            IDLE: ;
            PLAY: begin
               if (bus.game_over) state_d = DRAIN;
            end
            DRAIN: begin
               if (pending_q == 6'd0 && !increment_q) begin
                  state_d   = BROWSE;
                  en_d      = 1'b1;
                  decider_d = 2'd0;
                  timer_d   = '0;
               end
            end
            BROWSE: begin
               if (bus.view || timer_q == TIMER_LAST) begin
                  decider_d = decider_q + 2'd1;
                  timer_d   = '0;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
         endcase

         // Strobing only while pulses may be owed; the low cycle after each
         // strobe comes from requiring increment_q == 0.
         if (state_q == PLAY || state_q == DRAIN) begin
            strobe      = !increment_q && pending_q != 6'd0 && score_q < SCORE_MAX;
            increment_d = strobe;
            if (strobe) score_d = score_q + 10'd1;
            if (score_q >= SCORE_MAX) begin
               pending_d = '0;
            end else begin
               pending_sum = {1'b0, pending_q}
                           + ((state_q == PLAY && bus.eat) ? {4'b0, bus.points} : 7'd0)
                           - {6'b0, strobe};
               pending_d   = (pending_sum > 7'd63) ? 6'd63 : pending_sum[5:0];
            end
         end
      end

      busy_d = (pending_d != 6'd0);
   end

   // NOTE: state registers use non-blocking assignments so all flops sample the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         score_q     <= '0;
         timer_q     <= '0;
         decider_q   <= 2'd0;
         increment_q <= 1'b0;
         en_q        <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         score_q     <= score_d;
         timer_q     <= timer_d;
         decider_q   <= decider_d;
         increment_q <= increment_d;
         en_q        <= en_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.increment = increment_q;
   assign bus.en        = en_q;
   assign bus.decider   = decider_q;
   assign bus.busy      = busy_q;
   assign bus.score     = score_q;
endmodule

// File: tb/tb_score_sequencer.sv
// Self-checking bench for score_sequencer: vector table with a scoreboard plus
// hand-written sequences for timing, drain, browse, reset and saturation.
module tb_score_sequencer;
   localparam int TICKS = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   score_sequencer_if bus ();
   score_sequencer_if bus_m ();

   score_sequencer #(.MAX_SCORE(999), .CYCLE_TICKS(TICKS)) u_dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   score_sequencer #(.MAX_SCORE(5), .CYCLE_TICKS(TICKS)) u_max (
      .clk(clk), .rst(rst), .bus(bus_m)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor: counts pulses, logs their edge index, checks pacing.
   int   strobes   = 0;
   int   strobes_m = 0;
   int   strobe_edges[$];
   logic prev_inc  = 1'b0;
   logic prev_en   = 1'b0;
   always @(negedge clk) begin
      if (bus.increment === 1'b1) begin
         strobes++;
         strobe_edges.push_back(cyc);
         check("pacing_low_gap", 32'(prev_inc), 0);
      end
      if (bus.en === 1'b1 && prev_en === 1'b0) check("en_after_low", 32'(prev_inc), 0);
      if (bus_m.increment === 1'b1) strobes_m++;
      prev_inc <= bus.increment;
      prev_en  <= bus.en;
   end

   typedef struct {
      logic [2:0] pa;
      int         gap;
      logic [2:0] pb;
      int         exp_n;
   } vec_t;

   typedef struct {
      int n;
      int score;
   } exp_t;

   vec_t vecs[6];
   exp_t sb[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic do_eat(input logic [2:0] p);
      bus.eat    = 1'b1;
      bus.points = p;
      tick();
      bus.eat    = 1'b0;
      bus.points = 3'd0;
   endtask

   task automatic wait_quiet(input string name, input int budget);
      int n = 0;
      @(negedge clk);
      while ((bus.busy !== 1'b0 || bus.increment !== 1'b0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(bus.busy | bus.increment), 0);
   endtask

   task automatic wait_en_rise(output int edge_idx);
      edge_idx = -1;
      for (int n = 0; n < 40 && edge_idx < 0; n++) begin
         tick();
         if (bus.en === 1'b1) edge_idx = cyc;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int   base, base_i, e0, eb, rise, idx;
      exp_t e;

      vecs[0] = '{pa: 3'd3, gap: 1,  pb: 3'd0, exp_n: 3};
      vecs[1] = '{pa: 3'd2, gap: 1,  pb: 3'd2, exp_n: 4};
      vecs[2] = '{pa: 3'd7, gap: 2,  pb: 3'd0, exp_n: 7};
      vecs[3] = '{pa: 3'd0, gap: 1,  pb: 3'd0, exp_n: 0};
      vecs[4] = '{pa: 3'd1, gap: 3,  pb: 3'd6, exp_n: 7};
      vecs[5] = '{pa: 3'd5, gap: 20, pb: 3'd4, exp_n: 9};

      {bus.start, bus.eat, bus.points, bus.game_over, bus.view} = '0;
      {bus_m.start, bus_m.eat, bus_m.points, bus_m.game_over, bus_m.view} = '0;
      rst = 1'b0;
      #12;
      check("rst_increment", 32'(bus.increment), 0);
      check("rst_en",        32'(bus.en), 0);
      check("rst_decider",   32'(bus.decider), 0);
      check("rst_busy",      32'(bus.busy), 0);
      check("rst_score",     32'(bus.score), 0);
      #10 rst = 1'b1;

      // Table vectors: expectation pushed at stimulus, popped once the burst drains.
      for (int i = 0; i < 6; i++) begin
         pulse_start();
         base = strobes;
         do_eat(vecs[i].pa);
         repeat (vecs[i].gap - 1) tick();
         do_eat(vecs[i].pb);
         e.n     = vecs[i].exp_n;
         e.score = vecs[i].exp_n;
         sb.push_back(e);
         wait_quiet("vec_quiet", 200);
         e = sb.pop_front();
         check($sformatf("vec%0d_strobes", i), strobes - base, e.n);
         check($sformatf("vec%0d_score", i), 32'(bus.score), e.score);
      end

      // Exact strobe edges for a 3-point eat; busy falls after the third strobe.
      pulse_start();
      base_i = strobe_edges.size();
      do_eat(3'd3);
      e0 = cyc;
      check("t3_busy_rise", 32'(bus.busy), 1);
      repeat (4) tick();
      check("t3_busy_e4", 32'(bus.busy), 1);
      tick();
      check("t3_busy_e5", 32'(bus.busy), 0);
      repeat (3) tick();
      check("t3_count", strobe_edges.size() - base_i, 3);
      for (int k = 0; k < 3; k++) begin
         idx = base_i + k;
         check($sformatf("t3_edge%0d", k),
               (idx < strobe_edges.size()) ? strobe_edges[idx] : -1, e0 + 1 + 2 * k);
      end
      check("t3_score", 32'(bus.score), 3);

      // game_over one cycle after eat 5; a DRAIN-time eat must be ignored.
      pulse_start();
      base = strobes;
      do_eat(3'd5);
      e0 = cyc;
      bus.game_over = 1'b1;
      tick();
      bus.game_over = 1'b0;
      check("go_en_low", 32'(bus.en), 0);
      tick();
      do_eat(3'd4);
      wait_en_rise(rise);
      check("go_en_edge", rise, e0 + 11);
      check("go_strobes", strobes - base, 5);
      check("go_decider", 32'(bus.decider), 0);

      // eat coincident with game_over is credited, then browse timing.
      pulse_start();
      base = strobes;
      bus.eat = 1'b1; bus.points = 3'd2; bus.game_over = 1'b1;
      tick();
      bus.eat = 1'b0; bus.points = 3'd0; bus.game_over = 1'b0;
      e0 = cyc;
      wait_en_rise(eb);
      check("cog_en_edge", eb, e0 + 5);
      check("cog_strobes", strobes - base, 2);
      for (int t = 1; t <= 16; t++) begin
         tick();
         check($sformatf("browse_t%0d", t), 32'(bus.decider), (t / TICKS) % 4);
      end
      bus.view = 1'b1;
      tick();
      bus.view = 1'b0;
      check("view_advance", 32'(bus.decider), 1);
      for (int t = 1; t <= TICKS; t++) begin
         if (t == 1) begin
            bus.game_over = 1'b1; bus.eat = 1'b1; bus.points = 3'd7;
         end
         tick();
         bus.game_over = 1'b0; bus.eat = 1'b0; bus.points = 3'd0;
         check($sformatf("view_t%0d", t), 32'(bus.decider), (t < TICKS) ? 1 : 2);
      end
      check("browse_en_hold", 32'(bus.en), 1);
      check("browse_busy", 32'(bus.busy), 0);
      pulse_start();
      check("start_en", 32'(bus.en), 0);
      check("start_decider", 32'(bus.decider), 0);

      // start beats game_over and discards a same-cycle eat.
      bus.start = 1'b1; bus.game_over = 1'b1; bus.eat = 1'b1; bus.points = 3'd7;
      tick();
      bus.start = 1'b0; bus.game_over = 1'b0; bus.eat = 1'b0; bus.points = 3'd0;
      base = strobes;
      repeat (6) tick();
      check("start_eat_discard", strobes - base, 0);
      check("start_eat_busy", 32'(bus.busy), 0);
      do_eat(3'd1);
      wait_quiet("start_win_quiet", 50);
      check("start_win_play", strobes - base, 1);
      check("start_win_en", 32'(bus.en), 0);

      // pending saturates at 63 under a stream of 7-point eats.
      pulse_start();
      base = strobes;
      bus.eat = 1'b1; bus.points = 3'd7;
      repeat (10) tick();
      bus.eat = 1'b0; bus.points = 3'd0;
      wait_quiet("sat_quiet", 300);
      check("sat_strobes", strobes - base, 68);
      check("sat_score", 32'(bus.score), 68);

      // Asynchronous reset in the middle of a drain.
      pulse_start();
      do_eat(3'd7);
      bus.game_over = 1'b1;
      tick();
      bus.game_over = 1'b0;
      repeat (2) tick();
      check("mid_inc_before", 32'(bus.increment), 1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_inc",   32'(bus.increment), 0);
      check("mid_rst_busy",  32'(bus.busy), 0);
      check("mid_rst_score", 32'(bus.score), 0);
      check("mid_rst_en",    32'(bus.en), 0);
      #3 rst = 1'b1;
      base = strobes;
      do_eat(3'd3);
      repeat (4) tick();
      check("idle_no_strobe", strobes - base, 0);
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_score", 32'(bus.score), 0);

      // MAX_SCORE = 5 instance: saturation clears pending.
      bus_m.start = 1'b1;
      tick();
      bus_m.start = 1'b0;
      base = strobes_m;
      bus_m.eat = 1'b1; bus_m.points = 3'd7;
      tick();
      bus_m.eat = 1'b0; bus_m.points = 3'd0;
      for (int n = 0; n < 40 && (bus_m.busy !== 1'b0 || bus_m.increment !== 1'b0); n++) tick();
      check("max_quiet", 32'(bus_m.busy | bus_m.increment), 0);
      check("max_strobes", strobes_m - base, 5);
      check("max_score", 32'(bus_m.score), 5);
      bus_m.eat = 1'b1; bus_m.points = 3'd3;
      tick();
      bus_m.eat = 1'b0; bus_m.points = 3'd0;
      check("max_eat_busy", 32'(bus_m.busy), 0);
      repeat (6) tick();
      check("max_no_more", strobes_m - base, 5);
      check("max_score_hold", 32'(bus_m.score), 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
